// File: rtl/verdict_collector.sv
// verdict_collector: captures the monitor's active output lanes each enabled
// cycle, stamps them with a free-running cycle count and buffers the records
// in a first-word-fall-through FIFO drained over a valid/ready handshake.
//
// Handshake: a record transfers on every posedge where rec_valid=1 and
// rec_ready=1; rec_valid never depends on rec_ready, and rec_ready while the
// FIFO is empty has no effect.
//
// Optional feature macro: VERDICT_COLLECTOR_DEDUP_EN suppresses captures whose
// mask and masked lane data repeat the most recently captured record.
module verdict_collector #(
    parameter int NUM_OUT = 4,
    parameter int DATA_W  = 64,
    parameter int TS_W    = 32,
    parameter int DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NUM_OUT*DATA_W-1:0]   out_data,
    input  logic [NUM_OUT-1:0]          out_aktv,
    output logic                        rec_valid,
    input  logic                        rec_ready,
    output logic [TS_W-1:0]             rec_ts,
    output logic [NUM_OUT-1:0]          rec_mask,
    output logic [NUM_OUT*DATA_W-1:0]   rec_data,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow,
    output logic [15:0]                 drop_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int DATA_T = NUM_OUT * DATA_W;
    localparam int REC_W  = TS_W + NUM_OUT + DATA_T;

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_count_q, drop_count_d;

    logic [REC_W-1:0]  mem_q [DEPTH];
    logic [REC_W-1:0]  head;

    logic [DATA_T-1:0] masked_data;
    logic              capture;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              full;
    logic              drop;

    // Zero every lane whose aktv flag is clear so stale values never reach the log
    always_comb begin
        masked_data = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (out_aktv[i]) begin
                masked_data[i*DATA_W +: DATA_W] = out_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign capture = en && (|out_aktv);

`ifdef VERDICT_COLLECTOR_DEDUP_EN
    logic [NUM_OUT-1:0] last_mask_q, last_mask_d;
    logic [DATA_T-1:0]  last_data_q, last_data_d;
    logic               is_dup;

    // A cleared mask can never match a real capture (mask is non-zero), so the
    // first capture after reset always passes.
    assign is_dup   = (out_aktv == last_mask_q) && (masked_data == last_data_q);
    assign push_req = capture && !is_dup;

    // Remember the last record that actually entered the FIFO
    always_comb begin
        last_mask_d = last_mask_q;
        last_data_d = last_data_q;
        if (push_ok) begin
            last_mask_d = out_aktv;
            last_data_d = masked_data;
        end
    end

    // Last-record register for repeat suppression
    always_ff @(posedge clk) begin
        if (rst) begin
            last_mask_q <= '0;
            last_data_q <= '0;
        end else begin
            last_mask_q <= last_mask_d;
            last_data_q <= last_data_d;
        end
    end
`else
    assign push_req = capture;
`endif

    // Full/empty come from the occupancy count; a pop on a full FIFO frees the slot
    assign full      = (level_q == LVL_W'(DEPTH));
    assign pop       = (level_q != '0) && rec_ready;
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    // Next-state for timestamp, pointers, occupancy and drop bookkeeping
    always_comb begin
        ts_d         = ts_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (en) begin
            ts_d = ts_q + TS_W'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    // Control registers; reset flushes the FIFO without any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            ts_q         <= ts_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Record storage; contents are only meaningful below the occupancy count
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= {ts_q, out_aktv, masked_data};
        end
    end

    // Head record is read straight from storage and forced to zero when empty
    always_comb begin
        head      = mem_q[rd_ptr_q];
        rec_valid = (level_q != '0);
        rec_ts    = '0;
        rec_mask  = '0;
        rec_data  = '0;
        if (rec_valid) begin
            rec_ts   = head[REC_W-1 -: TS_W];
            rec_mask = head[DATA_T +: NUM_OUT];
            rec_data = head[DATA_T-1:0];
        end
    end

    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_verdict_collector.sv
// Bench for verdict_collector: directed scenarios plus a randomized phase,
// with a queue-based reference model and a scoreboard monitor.
module tb_verdict_collector;

    localparam int NUM_OUT = 4;
    localparam int DATA_W  = 64;
    localparam int TS_W    = 32;
    localparam int DEPTH   = 16;
    localparam int DATA_T  = NUM_OUT * DATA_W;
    localparam int REC_W   = TS_W + NUM_OUT + DATA_T;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                en = 1'b0;
    logic [DATA_T-1:0]   out_data = '0;
    logic [NUM_OUT-1:0]  out_aktv = '0;
    logic                rec_ready = 1'b0;
    logic                rec_valid;
    logic [TS_W-1:0]     rec_ts;
    logic [NUM_OUT-1:0]  rec_mask;
    logic [DATA_T-1:0]   rec_data;
    logic [4:0]          level;
    logic                overflow;
    logic [15:0]         drop_count;

    verdict_collector #(
        .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .out_data(out_data), .out_aktv(out_aktv),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_ts(rec_ts), .rec_mask(rec_mask), .rec_data(rec_data),
        .level(level), .overflow(overflow), .drop_count(drop_count)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [REC_W-1:0]   exp_q[$];
    logic [TS_W-1:0]    mdl_ts = '0;
    int                 mdl_level = 0;
    int                 mdl_drops = 0;
    bit                 mdl_ovf = 1'b0;
    bit                 pend_push = 1'b0;
    logic [NUM_OUT-1:0] last_mask = '0;
    logic [DATA_T-1:0]  last_data = '0;
    int                 max_level = 0;

    function automatic logic [DATA_T-1:0] pack4(input logic [63:0] l0, input logic [63:0] l1,
                                                input logic [63:0] l2, input logic [63:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [DATA_T-1:0] mask_lanes(input logic [NUM_OUT-1:0] m,
                                                     input logic [DATA_T-1:0] d);
        logic [DATA_T-1:0] r;
        r = d;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (!m[i]) r[i*DATA_W +: DATA_W] = '0;
        end
        return r;
    endfunction

    // driver: apply one cycle of inputs, predict its effect, advance past the edge
    task automatic drive(input logic e, input logic [NUM_OUT-1:0] ak,
                         input logic [DATA_T-1:0] d, input logic rdy);
        logic [DATA_T-1:0] md;
        bit suppress;
        en = e; out_aktv = ak; out_data = d; rec_ready = rdy;
        if (mdl_level > 0 && rdy) mdl_level--;
        pend_push = 1'b0;
        if (e && ak != '0) begin
            md = mask_lanes(ak, d);
            suppress = 1'b0;
`ifdef VERDICT_COLLECTOR_DEDUP_EN
            suppress = (ak == last_mask) && (md == last_data);
`endif
            if (!suppress) begin
                if (mdl_level < DEPTH) begin
                    exp_q.push_back({mdl_ts, ak, md});
                    mdl_level++;
                    pend_push = 1'b1;
                    last_mask = ak;
                    last_data = md;
                end else begin
                    mdl_ovf = 1'b1;
                    if (mdl_drops < 16'hFFFF) mdl_drops++;
                end
            end
        end
        if (e) mdl_ts = mdl_ts + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; out_aktv = '0; rec_ready = 1'b0;
        exp_q.delete();
        mdl_ts = '0; mdl_level = 0; mdl_drops = 0; mdl_ovf = 1'b0;
        pend_push = 1'b0; last_mask = '0; last_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_status(input string name, input int exp_level, input bit exp_valid,
                                input bit exp_ovf, input int exp_drops);
        checks++;
        if (int'(level) != exp_level || rec_valid !== exp_valid ||
            overflow !== exp_ovf || int'(drop_count) != exp_drops) begin
            errors++;
            $display("FAIL %s: level=%0d valid=%b ovf=%b drops=%0d, need level=%0d valid=%b ovf=%b drops=%0d",
                     name, level, rec_valid, overflow, drop_count,
                     exp_level, exp_valid, exp_ovf, exp_drops);
        end
    endtask

    task automatic check_head(input string name, input logic [TS_W-1:0] ts,
                              input logic [NUM_OUT-1:0] m, input logic [DATA_T-1:0] d);
        checks++;
        if (rec_ts !== ts || rec_mask !== m || rec_data !== d) begin
            errors++;
            $display("FAIL %s: ts=%0d mask=%b data=%h, need ts=%0d mask=%b data=%h",
                     name, rec_ts, rec_mask, rec_data, ts, m, d);
        end
    endtask

    // drain with bounded cycle budget; an undrained FIFO shows up in the status check
    task automatic drain(input string name);
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (level == 0) break;
            drive(1'b0, '0, '0, 1'b1);
        end
        check_status(name, 0, 1'b0, mdl_ovf, mdl_drops);
    endtask

    // scoreboard monitor: samples mid-cycle, pops expected records on each handshake
    always @(negedge clk) begin
        logic [REC_W-1:0] r;
        if (!rst) begin
            if (int'(level) > max_level) max_level = int'(level);
            checks++;
            if (int'(level) != exp_q.size() - int'(pend_push)) begin
                errors++;
                $display("FAIL level_track: level=%0d need %0d", level,
                         exp_q.size() - int'(pend_push));
            end
            if (rec_valid && rec_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_order: popped ts=%0d with no expected record", rec_ts);
                end else begin
                    r = exp_q.pop_front();
                    if ({rec_ts, rec_mask, rec_data} !== r) begin
                        errors++;
                        $display("FAIL pop_order: got ts=%0d mask=%b data=%h, need ts=%0d mask=%b data=%h",
                                 rec_ts, rec_mask, rec_data, r[REC_W-1 -: TS_W],
                                 r[DATA_T +: NUM_OUT], r[DATA_T-1:0]);
                    end
                end
            end
            if (!rec_valid) begin
                checks++;
                if (rec_ts !== '0 || rec_mask !== '0 || rec_data !== '0) begin
                    errors++;
                    $display("FAIL empty_head: ts=%0d mask=%b data=%h, need all zero",
                             rec_ts, rec_mask, rec_data);
                end
            end
        end
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, need completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_T-1:0] d;
        logic [NUM_OUT-1:0] ak;
        do_reset();
        check_status("reset", 0, 1'b0, 1'b0, 0);

        // idle ten cycles, then one capture carrying ts=10
        repeat (10) drive(1'b1, '0, '0, 1'b0);
        check_status("idle", 0, 1'b0, 1'b0, 0);
        drive(1'b1, 4'b0101, pack4(1, 7, 3, 9), 1'b0);
        check_status("single_status", 1, 1'b1, 1'b0, 0);
        check_head("single_head", 32'd10, 4'b0101, pack4(1, 0, 3, 0));
        drive(1'b1, '0, '0, 1'b1);
        check_status("single_pop", 0, 1'b0, 1'b0, 0);

        // back-to-back with a permanently ready consumer
        max_level = 0;
        for (int v = 1; v <= 3; v++) drive(1'b1, 4'b1111, pack4(v, v, v, v), 1'b1);
        repeat (3) drive(1'b1, '0, '0, 1'b1);
        check_status("b2b_status", 0, 1'b0, 1'b0, 0);
        checks++;
        if (max_level > 1) begin
            errors++;
            $display("FAIL b2b_level: max level=%0d need <=1", max_level);
        end

        // overflow: 20 captures into a 16-deep FIFO, then a push on full with a pop
        for (int i = 0; i < 20; i++) begin
            d = {8{$urandom()}};
            drive(1'b1, 4'($urandom_range(1, 15)), d, 1'b0);
        end
        check_status("ovf_status", 16, 1'b1, 1'b1, 4);
        drive(1'b1, 4'b1000, pack4(0, 0, 0, 77), 1'b1);
        check_status("full_push_pop", 16, 1'b1, 1'b1, 4);
        drain("ovf_drain");

        // en=0 freezes the timestamp and captures nothing
        do_reset();
        repeat (3) drive(1'b1, '0, '0, 1'b0);
        repeat (5) drive(1'b0, 4'b1111, pack4(5, 6, 7, 8), 1'b0);
        check_status("en_off", 0, 1'b0, 1'b0, 0);
        drive(1'b1, 4'b0010, pack4(0, 11, 0, 0), 1'b0);
        check_head("frozen_ts", 32'd3, 4'b0010, pack4(0, 11, 0, 0));
        drive(1'b1, 4'b0100, pack4(0, 0, 12, 0), 1'b0);
        drive(1'b1, 4'b1000, pack4(0, 0, 0, 13), 1'b0);
        check_status("fill3", 3, 1'b1, 1'b0, 0);
        do_reset();
        check_status("mid_reset", 0, 1'b0, 1'b0, 0);
        drive(1'b1, 4'b0001, pack4(99, 0, 0, 0), 1'b0);
        check_head("post_reset_ts", 32'd0, 4'b0001, pack4(99, 0, 0, 0));

        // repeat suppression stimulus
        do_reset();
        drive(1'b1, 4'b0001, pack4(42, 0, 0, 0), 1'b0);
        drive(1'b1, 4'b0001, pack4(42, 5, 0, 0), 1'b0);
        drive(1'b1, 4'b0001, pack4(43, 0, 0, 0), 1'b0);
`ifdef VERDICT_COLLECTOR_DEDUP_EN
        check_status("dedup_count", 2, 1'b1, 1'b0, 0);
`else
        check_status("dedup_count", 3, 1'b1, 1'b0, 0);
`endif
        check_head("dedup_head", 32'd0, 4'b0001, pack4(42, 0, 0, 0));
        drain("dedup_drain");

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ak = 4'($urandom_range(0, 15));
            for (int l = 0; l < NUM_OUT; l++) d[l*DATA_W +: DATA_W] = 64'($urandom_range(0, 2));
            drive(($urandom_range(0, 3) != 0), ak, d, ($urandom_range(0, 2) == 0));
        end
        check_status("rand_status", mdl_level, (mdl_level != 0), mdl_ovf, mdl_drops);
        drain("rand_drain");
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected records never seen, need 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
